// File: rtl/traffic_sensor_conditioner.sv
// Car-sensor front end: per-street 2-FF sync, debounce, arrival counting and queue FSM.
// Optional stuck-loop detection with fail-safe request is enabled by defining SENSOR_STUCK_DET_EN.
module traffic_sensor_conditioner #(
  parameter int DB_CYCLES    = 4,
  parameter int CNT_W        = 4,
  parameter int STUCK_CYCLES = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_a_i,
  input  logic             loop_b_i,
  input  logic             ga_i,
  input  logic             gb_i,
  output logic             sa_o,
  output logic             sb_o,
  output logic [CNT_W-1:0] qa_o,
  output logic [CNT_W-1:0] qb_o,
  output logic [1:0]       sat_o,
  output logic [1:0]       stuck_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SERVED  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] Q_MAX   = {CNT_W{1'b1}};
  localparam logic [7:0]       DB_LAST = 8'(DB_CYCLES - 1);

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_bad_db_cycles
    $error("traffic_sensor_conditioner: DB_CYCLES must be within 1..255");
  end
  if (STUCK_CYCLES < 1) begin : g_bad_stuck_cycles
    $error("traffic_sensor_conditioner: STUCK_CYCLES must be positive");
  end

  logic [1:0]       loop_raw;
  logic [1:0]       green;
  logic             s_vec     [2];
  logic             sat_vec   [2];
  logic             stuck_vec [2];
  logic [CNT_W-1:0] q_vec     [2];

  assign loop_raw = {loop_b_i, loop_a_i};
  assign green    = {gb_i, ga_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic             sync1_reg;
    logic             sync2_reg;
    logic             filt_reg;
    logic             filt_d_reg;
    logic [7:0]       dbc_reg;
    logic             arrival;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] q_reg;
    logic [CNT_W-1:0] q_next;
    logic             sat_reg;
    logic             sat_next;
    logic             s_reg;
    logic             s_next;
    logic             stuck_next;

    // Synchronizer and debounce: filt follows the synced level only after DB_CYCLES agreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_reg  <= 1'b0;
        sync2_reg  <= 1'b0;
        filt_reg   <= 1'b0;
        filt_d_reg <= 1'b0;
        dbc_reg    <= '0;
      end else begin
        sync1_reg  <= loop_raw[gi];
        sync2_reg  <= sync1_reg;
        filt_d_reg <= filt_reg;
        if (sync2_reg == filt_reg) begin
          dbc_reg <= '0;
        end else if (dbc_reg == DB_LAST) begin
          filt_reg <= sync2_reg;
          dbc_reg  <= '0;
        end else begin
          dbc_reg <= dbc_reg + 8'd1;
        end
      end
    end

    assign arrival = filt_reg & ~filt_d_reg;

    always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      sat_next   = sat_reg;
      case (state_reg)
        IDLE: begin
          if (green[gi]) begin
            state_next = SERVED;
            q_next     = '0;
          end else if (arrival) begin
            state_next = WAITING;
            q_next     = CNT_W'(1);
          end
        end
        WAITING: begin
          if (green[gi]) begin
            state_next = SERVED;
            q_next     = '0;
          end else if (arrival) begin
            if (q_reg == Q_MAX) begin
              sat_next = 1'b1;
            end else begin
              q_next = q_reg + CNT_W'(1);
            end
          end
        end
        SERVED: begin
          q_next = '0;
          if (!green[gi]) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          q_next     = '0;
        end
      endcase
    end

`ifdef SENSOR_STUCK_DET_EN
    localparam int                 STUCK_W    = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] stk_cnt_reg;
    logic [STUCK_W-1:0] stk_cnt_next;
    logic               stuck_reg;

    // The counter saturates at STUCK_CYCLES so a permanently stuck loop cannot wrap it.
    always_comb begin
      stk_cnt_next = stk_cnt_reg;
      if (!filt_reg || green[gi]) begin
        stk_cnt_next = '0;
      end else if (stk_cnt_reg != STUCK_LAST) begin
        stk_cnt_next = stk_cnt_reg + STUCK_W'(1);
      end
    end

    assign stuck_next = stuck_reg | (stk_cnt_next == STUCK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stk_cnt_reg <= '0;
        stuck_reg   <= 1'b0;
      end else begin
        stk_cnt_reg <= stk_cnt_next;
        stuck_reg   <= stuck_next;
      end
    end

    assign stuck_vec[gi] = stuck_reg;
`else
    assign stuck_next    = 1'b0;
    assign stuck_vec[gi] = 1'b0;
`endif

    // A stuck loop keeps requesting service, but never while its street is already green.
    assign s_next = (state_next == WAITING) | (stuck_next & ~green[gi]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg <= IDLE;
        q_reg     <= '0;
        sat_reg   <= 1'b0;
        s_reg     <= 1'b0;
      end else begin
        state_reg <= state_next;
        q_reg     <= q_next;
        sat_reg   <= sat_next;
        s_reg     <= s_next;
      end
    end

    assign s_vec[gi]   = s_reg;
    assign sat_vec[gi] = sat_reg;
    assign q_vec[gi]   = q_reg;
  end

  assign sa_o    = s_vec[0];
  assign sb_o    = s_vec[1];
  assign qa_o    = q_vec[0];
  assign qb_o    = q_vec[1];
  assign sat_o   = {sat_vec[1], sat_vec[0]};
  assign stuck_o = {stuck_vec[1], stuck_vec[0]};

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Front end for the traffic light controller's car-sensor inputs: takes raw inductive-loop detector signals for streets A and B, synchronizes and debounces them, counts queued vehicles per street, and drives the clean "car waiting" levels the controller samples. It also consumes the controller's green outputs as feedback, so a queue is flushed when its street is served. It sits between the pad-level loop detectors and the controller's `Sa`/`Sb` inputs, in the controller's clock domain.

## Interface
- `DB_CYCLES`, default 4: consecutive synchronized cycles a loop level must differ from the filtered level before the filtered level changes; legal range 1–255.
- `CNT_W`, default 4: width of each queue counter; saturates at 2^CNT_W−1.
- `STUCK_CYCLES`, default 200: filtered-high duration that flags a stuck loop; only used with `SENSOR_STUCK_DET_EN`.

Ports:
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `loop_a_i  in  1`: raw loop detector, street A; asynchronous to `clk`.
- `loop_b_i  in  1`: raw loop detector, street B; asynchronous to `clk`.
- `ga_i  in  1`: green-A feedback from the controller, synchronous to `clk`.
- `gb_i  in  1`: green-B feedback from the controller, synchronous to `clk`.
- `sa_o  out  1`: car waiting on A; drives the controller's `Sa`.
- `sb_o  out  1`: car waiting on B; drives the controller's `Sb`.
- `qa_o  out  CNT_W`: queued-vehicle count, A.
- `qb_o  out  CNT_W`: queued-vehicle count, B.
- `sat_o  out  2`: sticky saturation flags, bit0 = A, bit1 = B.
- `stuck_o  out  2`: stuck-loop flags, bit0 = A, bit1 = B.

## Operation
- Two identical channels, A and B. Each channel has a 2-FF synchronizer, a debounce filter, an arrival detector and a 3-state FSM.
- **Debounce filter**
  - Counter `dbc` clears whenever the synchronized level equals the filtered level `filt`.
  - Otherwise `dbc` increments.
  - When `dbc == DB_CYCLES−1` and the levels still differ, `filt` takes the synchronized value at the next edge and `dbc` clears.
  - Glitches shorter than `DB_CYCLES` cycles never reach `filt`.
- **Arrival:** a one-cycle pulse on a `filt` 0→1 transition.
- **FSM states:** IDLE (q=0), WAITING (q>0), SERVED (street green).
  - IDLE → WAITING: arrival with green low; q becomes 1.
  - WAITING → WAITING: arrival with green low; q increments. At max, q holds and the channel's `sat_o` bit sets.
  - IDLE or WAITING → SERVED: green sampled high; q clears to 0.
  - SERVED → IDLE: green sampled low.
  - Arrivals while in SERVED, or on the same edge green is sampled high, are ignored. The car passes on green.
- `s*_o` = (state == WAITING), registered.
- `sat_o` bits clear only on reset.
- Both channels are fully independent. Simultaneous arrivals on A and B are both counted.

## Timing
- Raw rising edge to `filt` high: 2 sync + `DB_CYCLES` edges.
- Arrival to `q*_o`/`s*_o` update: 1 further edge. With defaults, the first rising edge sampling the raw loop high is followed by `sa_o` = 1 on the 7th edge (`DB_CYCLES`+3).
- Green feedback to flush: `q*_o` = 0 and `s*_o` = 0 on the same edge that samples `g*_i` = 1. No synchronizer on `g*_i`.
- **Reset values:** sync FFs 0, `filt` 0, `dbc` 0, state IDLE, `sa_o`/`sb_o` 0, `qa_o`/`qb_o` 0, `sat_o` 0, `stuck_o` 0.
- Reset asserted mid-debounce or mid-queue clears everything immediately, without waiting for a clock edge.
- A loop already high at reset release is counted as a fresh arrival after 2+`DB_CYCLES` edges.

## Configuration
- **`SENSOR_STUCK_DET_EN` defined:**
  - A per-channel counter runs while `filt` is 1 and clears when `filt` is 0 or the street's green is high.
  - Reaching `STUCK_CYCLES` sets that channel's `stuck_o` bit, which is sticky until reset.
  - While `stuck_o` is set, `s*_o` is forced to 1 (fail-safe request) whatever the FSM state, except when green is high.
- **`SENSOR_STUCK_DET_EN` undefined:** no stuck counter logic; `stuck_o` tied to 2'b00; `s*_o` comes purely from the FSM.

## Test plan
- Reset, then `loop_b_i` high for 10 cycles with `gb_i`=0 → `sb_o`=1 and `qb_o`=1 on the 7th edge after the first high sample; `sa_o` stays 0.
- 3-cycle glitch on `loop_a_i` → `filt`, `qa_o` and `sa_o` unchanged (0).
- Five separate 10-cycle pulses on A with `ga_i`=0, then `ga_i`=1 → `qa_o` steps 1..5; on the edge sampling `ga_i`=1, `qa_o`=0 and `sa_o`=0. An arrival during green leaves `qa_o`=0.
- With `CNT_W`=2: 4 arrivals on B → `qb_o` holds at 3 and `sat_o`=2'b10.
- Assert `rst_n`=0 mid-debounce with `qa_o`=2 → all outputs 0 asynchronously. Then re-release with `loop_a_i` still high → `qa_o`=1 after 2+`DB_CYCLES`+1 edges.
- With `SENSOR_STUCK_DET_EN` and `STUCK_CYCLES`=20: hold `loop_a_i` high → `stuck_o`[0]=1 after 20 filtered-high cycles, `sa_o` forced to 1. Undefined: `stuck_o` stays 0.
